// File: rtl/ise_image_sort_if.sv
// Pixel-in / result-out signal bundle for the image sorting engine.
// The slave modport is the engine side; the master modport is the source/consumer side.
interface ise_image_sort_if #(
  parameter int IDX_W = 5
);
  logic [IDX_W-1:0] image_in_index;
  logic [23:0]      pixel_in;
  logic             busy;
  logic             out_valid;
  logic [1:0]       color_index;
  logic [IDX_W-1:0] image_out_index;

  modport slave (
    input  image_in_index, pixel_in,
    output busy, out_valid, color_index, image_out_index
  );

  modport master (
    output image_in_index, pixel_in,
    input  busy, out_valid, color_index, image_out_index
  );
endinterface

// File: rtl/ise_image_sort.sv
// Streams a batch of RGB images, classifies each by dominant colour and average
// intensity, then emits the image indices in ascending {class, intensity, index} order.
module ise_image_sort #(
  parameter int IMAGE_NUM  = 32,
  parameter int IMAGE_SIZE = 128
) (
  input logic             clk,
  input logic             reset,
  ise_image_sort_if.slave bus
);
  localparam int PIX_NUM = IMAGE_SIZE * IMAGE_SIZE;
  localparam int PCNT_W  = $clog2(PIX_NUM);
  localparam int CNT_W   = PCNT_W + 1;
  localparam int SUM_W   = PCNT_W + 8;
  localparam int IDX_W   = $clog2(IMAGE_NUM);
  localparam int KEY_W   = IDX_W + 10;

  typedef enum logic [1:0] {S_RECEIVE, S_FINISH, S_OUTPUT} state_t;

  state_t             state;
  logic               busy;
  logic               out_valid;
  logic [1:0]         color_index;
  logic [IDX_W-1:0]   image_out_index;

  logic [PCNT_W-1:0]  pix_cnt;
  logic [IDX_W-1:0]   img_cnt;
  logic [IDX_W-1:0]   cur_idx;
  logic [CNT_W-1:0]   cnt_r, cnt_g, cnt_b;
  logic [SUM_W-1:0]   sum_r, sum_g, sum_b;

  logic               div_busy;
  logic [2:0]         div_step;
  logic [SUM_W-1:0]   div_rem, div_d;
  logic [7:0]         div_q;
  logic [1:0]         div_cls;
  logic [IDX_W-1:0]   div_idx;

  logic [KEY_W-1:0]   tbl_key [IMAGE_NUM];
  logic [IMAGE_NUM-1:0] tbl_vld;

  // Per-pixel datapath and the accumulator values after the current pixel.
  logic [7:0]         r, g, b, pix_val;
  logic [1:0]         pix_cls, img_cls;
  logic               accept, first_pix, last_pix;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt_r_nxt, cnt_g_nxt, cnt_b_nxt, sel_cnt;
  logic [SUM_W-1:0]   sum_r_nxt, sum_g_nxt, sum_b_nxt, sel_sum;

  assign r         = bus.pixel_in[23:16];
  assign g         = bus.pixel_in[15:8];
  assign b         = bus.pixel_in[7:0];
  assign accept    = !busy;
  assign first_pix = (pix_cnt == '0);
  assign last_pix  = (pix_cnt == PCNT_W'(PIX_NUM - 1));
  assign idx_nxt   = first_pix ? bus.image_in_index : cur_idx;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pix_cls = 2'd2;
    pix_val = b;
    if (r >= g && r >= b) begin
      pix_cls = 2'd0;
      pix_val = r;
    end else if (g >= b) begin
      pix_cls = 2'd1;
      pix_val = g;
    end

    cnt_r_nxt = first_pix ? '0 : cnt_r;
    cnt_g_nxt = first_pix ? '0 : cnt_g;
    cnt_b_nxt = first_pix ? '0 : cnt_b;
    sum_r_nxt = first_pix ? '0 : sum_r;
    sum_g_nxt = first_pix ? '0 : sum_g;
    sum_b_nxt = first_pix ? '0 : sum_b;
    case (pix_cls)
      2'd0: begin
        cnt_r_nxt = cnt_r_nxt + CNT_W'(1);
        sum_r_nxt = sum_r_nxt + SUM_W'(pix_val);
      end
      2'd1: begin
        cnt_g_nxt = cnt_g_nxt + CNT_W'(1);
        sum_g_nxt = sum_g_nxt + SUM_W'(pix_val);
      end
      default: begin
        cnt_b_nxt = cnt_b_nxt + CNT_W'(1);
        sum_b_nxt = sum_b_nxt + SUM_W'(pix_val);
      end
    endcase

    // Majority class; ties resolve towards red, then green.
    img_cls = 2'd2;
    sel_cnt = cnt_b_nxt;
    sel_sum = sum_b_nxt;
    if (cnt_r_nxt >= cnt_g_nxt && cnt_r_nxt >= cnt_b_nxt) begin
      img_cls = 2'd0;
      sel_cnt = cnt_r_nxt;
      sel_sum = sum_r_nxt;
    end else if (cnt_g_nxt >= cnt_b_nxt) begin
      img_cls = 2'd1;
      sel_cnt = cnt_g_nxt;
      sel_sum = sum_g_nxt;
    end
  end

  // Restoring divider: the quotient is known to fit 8 bits because every
  // summed value is at most 255, so only 8 shift-subtract steps are needed.
  logic       div_ge;
  logic [7:0] q_nxt;
  logic       tbl_we;

  assign div_ge = (div_rem >= div_d);
  assign q_nxt  = {div_q[6:0], div_ge};
  assign tbl_we = div_busy && (div_step == 3'd7);

  // Smallest unemitted key; keys are unique since they embed the image index.
  logic             min_found;
  logic [KEY_W-1:0] min_key;
  logic [IDX_W-1:0] min_slot;

  always_comb begin
    min_found = 1'b0;
    min_key   = '1;
    min_slot  = '0;
    for (int i = 0; i < IMAGE_NUM; i++) begin
      if (tbl_vld[i] && (!min_found || tbl_key[i] < min_key)) begin
        min_found = 1'b1;
        min_key   = tbl_key[i];
        min_slot  = IDX_W'(i);
      end
    end
  end

  // NOTE: the key table carries no reset; only its valid bits do, so the storage can map onto plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_key[div_idx] <= {div_cls, q_nxt, div_idx};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_RECEIVE;
      busy            <= 1'b0;
      out_valid       <= 1'b0;
      color_index     <= '0;
      image_out_index <= '0;
      pix_cnt         <= '0;
      img_cnt         <= '0;
      cur_idx         <= '0;
      cnt_r           <= '0;
      cnt_g           <= '0;
      cnt_b           <= '0;
      sum_r           <= '0;
      sum_g           <= '0;
      sum_b           <= '0;
      div_busy        <= 1'b0;
      div_step        <= '0;
      div_rem         <= '0;
      div_d           <= '0;
      div_q           <= '0;
      div_cls         <= '0;
      div_idx         <= '0;
      tbl_vld         <= '0;
    end else begin
      out_valid <= 1'b0;

      if (div_busy) begin
        div_rem  <= div_ge ? div_rem - div_d : div_rem;
        div_d    <= div_d >> 1;
        div_q    <= q_nxt;
        div_step <= div_step + 3'd1;
        if (div_step == 3'd7) begin
          div_busy         <= 1'b0;
          tbl_vld[div_idx] <= 1'b1;
        end
      end

      case (state)
        S_RECEIVE: begin
          if (accept) begin
            pix_cnt <= pix_cnt + PCNT_W'(1);
            cur_idx <= idx_nxt;
            cnt_r   <= cnt_r_nxt;
            cnt_g   <= cnt_g_nxt;
            cnt_b   <= cnt_b_nxt;
            sum_r   <= sum_r_nxt;
            sum_g   <= sum_g_nxt;
            sum_b   <= sum_b_nxt;
            if (last_pix) begin
              div_busy <= 1'b1;
              div_step <= '0;
              div_rem  <= sel_sum;
              div_d    <= SUM_W'(sel_cnt) << 7;
              div_q    <= '0;
              div_cls  <= img_cls;
              div_idx  <= idx_nxt;
              img_cnt  <= img_cnt + IDX_W'(1);
              if (img_cnt == IDX_W'(IMAGE_NUM - 1)) begin
                state <= S_FINISH;
                busy  <= 1'b1;
              end
            end
          end
        end
        S_FINISH: begin
          if (!div_busy) state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (min_found) begin
            out_valid          <= 1'b1;
            color_index        <= min_key[KEY_W-1 -: 2];
            image_out_index    <= min_key[IDX_W-1:0];
            tbl_vld[min_slot]  <= 1'b0;
          end else begin
            // Table drained: release the source one cycle after the last result.
            state   <= S_RECEIVE;
            busy    <= 1'b0;
            img_cnt <= '0;
            pix_cnt <= '0;
            tbl_vld <= '0;
          end
        end
        default: state <= S_RECEIVE;
      endcase
    end
  end

  assign bus.busy            = busy;
  assign bus.out_valid       = out_valid;
  assign bus.color_index     = color_index;
  assign bus.image_out_index = image_out_index;
endmodule

// File: tb/tb_ise_image_sort.sv
// Scoreboard bench for ise_image_sort, run with 8x8 images so whole batches stay short.
// Expected result sequences are hand-listed per batch; a negedge monitor pops and compares.
module tb_ise_image_sort;
  localparam int IMAGE_NUM  = 32;
  localparam int IMAGE_SIZE = 8;
  localparam int PIX_NUM    = IMAGE_SIZE * IMAGE_SIZE;

  logic clk = 1'b0;
  logic reset;

  ise_image_sort_if #(.IDX_W(5)) bus ();

  ise_image_sort #(
    .IMAGE_NUM (IMAGE_NUM),
    .IMAGE_SIZE(IMAGE_SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_got, mon_want;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every result strobe is popped against the scoreboard queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      pulse_cnt++;
      mon_got = {bus.color_index, bus.image_out_index};
      check("busy_during_output", {31'd0, bus.busy}, 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got class %0d idx %0d, expected no result",
                 bus.color_index, bus.image_out_index);
      end else begin
        mon_want = exp_q.pop_front();
        check($sformatf("result_%0d(class,idx)", pulse_cnt), {25'd0, mon_got}, {25'd0, mon_want});
      end
    end
  end

  function automatic int order_of(input int mode, input int k);
    case (mode)
      0:       return k;
      1:       return 31 - k;
      default: return (k * 13 + 7) % 32;
    endcase
  endfunction

  function automatic logic [23:0] pix(input int test, input int img, input int p);
    logic [7:0] v;
    case (test)
      1: begin
        v = 8'(img * 8);
        return {v, 16'h0000};
      end
      2: return (img < 10) ? 24'h0000FF : (img < 20) ? 24'h00FF00 : 24'hFF0000;
      default: begin
        case (img)
          0:       return 24'h000000;
          1:       return (p < 40) ? 24'h0000FF : 24'hFF0000;
          3:       return 24'h190000;
          5:       return (p < 32) ? 24'h800000 : 24'h008000;
          6:       return 24'h808080;
          7:       return (p < 32) ? 24'h100000 : 24'h210000;
          8:       return 24'h180000;
          9:       return (p < 32) ? 24'h000040 : 24'h004000;
          10:      return 24'h000020;
          default: return 24'h0000FF;
        endcase
      end
    endcase
  endfunction

  task automatic push_pair(input int cls, input int idx);
    exp_q.push_back({2'(cls), 5'(idx)});
  endtask

  task automatic push_expected(input int test);
    int red_order[6];
    case (test)
      1: for (int i = 0; i < 32; i++) push_pair(0, i);
      2: begin
        for (int i = 20; i < 32; i++) push_pair(0, i);
        for (int i = 10; i < 20; i++) push_pair(1, i);
        for (int i = 0; i < 10; i++) push_pair(2, i);
      end
      default: begin
        // Red by intensity: 0(0x00) 7(0x18) 8(0x18) 3(0x19) 5(0x80) 6(0x80).
        red_order = '{0, 7, 8, 3, 5, 6};
        for (int i = 0; i < 6; i++) push_pair(0, red_order[i]);
        push_pair(1, 9);
        push_pair(2, 10);
        push_pair(2, 1);
        push_pair(2, 2);
        push_pair(2, 4);
        for (int i = 11; i < 32; i++) push_pair(2, i);
      end
    endcase
  endtask

  // Entered and left at #1 after a rising edge; one pixel per cycle.
  task automatic stream(input int test, input int mode, input int n_img, output int busy_seen);
    int img;
    busy_seen = 0;
    for (int k = 0; k < n_img; k++) begin
      img = order_of(mode, k);
      for (int p = 0; p < PIX_NUM; p++) begin
        bus.image_in_index = 5'(img);
        bus.pixel_in       = pix(test, img, p);
        if (bus.busy !== 1'b0) busy_seen++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_batch(input int test, input int mode);
    int busy_seen, base, first_lat, waited;
    push_expected(test);
    base = pulse_cnt;
    stream(test, mode, IMAGE_NUM, busy_seen);
    check($sformatf("t%0d_busy_low_while_streaming", test), busy_seen, 0);
    bus.pixel_in       = 'x;
    bus.image_in_index = 'x;
    check($sformatf("t%0d_busy_after_last_pixel", test), {31'd0, bus.busy}, 32'd1);
    first_lat = -1;
    waited    = 0;
    while (pulse_cnt < base + IMAGE_NUM && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
      if (first_lat < 0 && pulse_cnt > base) first_lat = waited;
    end
    check($sformatf("t%0d_result_count", test), pulse_cnt - base, IMAGE_NUM);
    // Pulses are counted on the falling edge, so the observed latency is one cycle late.
    check($sformatf("t%0d_first_result_within_64", test),
          {31'd0, (first_lat > 0 && first_lat <= 65)}, 32'd1);
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check($sformatf("t%0d_busy_falls", test), {31'd0, bus.busy}, 32'd0);
    check($sformatf("t%0d_queue_drained", test), exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int bs;
    reset              = 1'b0;
    bus.pixel_in       = '0;
    bus.image_in_index = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {25'd0, bus.busy, bus.out_valid, bus.color_index, bus.image_out_index}, 32'd0);
    reset = 1'b1;

    run_batch(1, 1);
    run_batch(2, 0);
    run_batch(3, 2);

    // Abort a batch three images in; outputs still hold the previous batch's last result.
    stream(1, 0, 3, bs);
    check("partial_busy_low", bs, 0);
    #2 reset = 1'b0;
    #1 check("reset_outputs_midbatch",
             {25'd0, bus.busy, bus.out_valid, bus.color_index, bus.image_out_index}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    run_batch(2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ise_image_sort.md
# ise_image_sort

Image sorting engine. It receives 32 RGB images of 128×128 pixels as a pixel stream and classifies each image as red-, green- or blue-dominant. It computes each image's average intensity in its dominant colour. It then emits the 32 image indices sorted by colour class, then intensity. It sits between the pixel source (throttled by `busy`) and a result consumer that samples `out_valid`.

## Interface
- IMAGE_NUM, 32, images per batch
- IMAGE_SIZE, 128, pixels per image side; 16384 pixels per image
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- image_in_index  in  5  index of the image the current pixel belongs to
- pixel_in  in  24  pixel value: R=[23:16], G=[15:8], B=[7:0]
- busy  out  1  high = source must hold its inputs
- out_valid  out  1  one-cycle strobe per sorted result
- color_index  out  2  result class: 0=red, 1=green, 2=blue (3 never driven)
- image_out_index  out  5  result image index

## Operation
- Pixel accept: a pixel is consumed at every rising edge where `busy` was low during the preceding cycle.
- Image boundaries:
  - Images arrive contiguously, 16384 pixels each, in arbitrary index order; each index appears once per batch.
  - `image_in_index` is latched with each image's first pixel.
  - A 14-bit pixel counter marks image end on wrap.
- Per-pixel class:
  - red if R>=G and R>=B;
  - else green if G>=B;
  - else blue.
- Per-image accumulators, cleared at each image start:
  - count_r/g/b: 15 bits each, max 16384.
  - sum_r/g/b: 22 bits each; sum of the winning channel value over pixels of that class.
- Image class: the class with the largest count. Ties go to red, then green.
- Intensity: floor(sum_class / count_class), 8 bits. count_class >= 5462, so there is no divide-by-zero.
  - A sequential divider may run during the next image's streaming.
  - It must finish before the next image ends.
- Record table: 32 entries, each stored as key = {class[1:0], intensity[7:0], index[4:0]} (15 bits, unique per image).
- Output phase starts after the 32nd image's last pixel is accepted and its intensity resolved.
  - Emit records in strictly ascending key order: red before green before blue, then ascending intensity, then ascending image index.
  - Repeated min-select over unemitted entries is acceptable.
- States: IDLE/RECEIVE → FINISH (last division) → OUTPUT (32 results) → RECEIVE (new batch; all counters and the table cleared).

## Timing
- Reset values:
  - busy=0, out_valid=0, color_index=0, image_out_index=0.
  - All counters, accumulators, table valid bits and the FSM cleared; FSM in RECEIVE.
- busy:
  - Low throughout the receive phase, so one pixel is accepted per cycle with no bubbles.
  - Goes high the cycle after the 524288th pixel is accepted.
  - Stays high until the cycle after the 32nd out_valid.
- Outputs:
  - color_index and image_out_index are valid only while out_valid=1; otherwise they hold their last value.
  - Exactly 32 out_valid pulses per batch, one cycle each, consecutive or not.
  - First pulse no later than 64 cycles after the final pixel.
  - Last pulse no later than 200 cycles after the final pixel.
- Inputs while busy=1 are ignored. Undriven (X/Z) inputs during busy or after the batch must not corrupt state.
- Reset mid-batch: asynchronous abort, everything returns to reset values; the next accepted pixel starts image 0 of a new batch.
- Boundary cases:
  - An image whose pixels are all one colour gives count=16384 (no counter overflow) and intensity = that channel value.
  - An image of all-zero pixels is red, intensity 0.

## Test plan
- All 32 images uniform: image k = pixel {R=k*8, G=0, B=0}, sent in order 31..0 → 32 results, class 0, indices 0..31 ascending.
- Images 0–9 pure blue 0x0000FF, 10–19 pure green 0x00FF00, 20–31 pure red 0xFF0000 → outputs in this order:
  - 20..31 with class 0,
  - then 10..19 with class 1,
  - then 0..9 with class 2.
- Tie test:
  - image 5 is half 0x800000 and half 0x008000 → class 0, intensity 0x80.
  - image 6 is all 0x808080 → red, intensity 0x80.
  - Both red at intensity 0x80, so 5 is emitted before 6.
- Averaging: red image with 8192 pixels R=0x10 plus 8192 pixels R=0x21 (G=B=0) → intensity floor(0x31*8192/16384)=0x18; its rank among other red images checks truncation.
- busy/handshake:
  - busy=0 for all 524288 input cycles;
  - busy rises after the final pixel;
  - 32 out_valid pulses within 200 cycles;
  - busy falls, and a second batch sorts correctly.
- Assert reset after 3 images mid-stream, then send a full batch → results reflect only the new batch, and all outputs are 0 during reset.
